// File: rtl/instr_fetch_stage_if.sv
// Bus bundle for the instruction-fetch stage: instruction-memory port,
// hazard/redirect controls from downstream, and the IF/ID register outputs.
// The fetch stage connects through the master modport; the surrounding
// core (or a testbench) connects through the slave modport.
interface instr_fetch_stage_if;
  // instruction memory (combinational read)
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  // pipeline control
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  // IF/ID pipeline register
  logic        ifid_valid_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_pc_plus4_o;
  logic [31:0] ifid_instr_o;
  logic        ifid_pred_taken_o;
  // statistics
  logic [31:0] fetch_count_o;

  modport master (
    output imem_addr_o,
    input  imem_rdata_i,
    input  stall_i,
    input  redirect_i,
    input  redirect_pc_i,
    output ifid_valid_o,
    output ifid_pc_o,
    output ifid_pc_plus4_o,
    output ifid_instr_o,
    output ifid_pred_taken_o,
    output fetch_count_o
  );

  modport slave (
    input  imem_addr_o,
    output imem_rdata_i,
    output stall_i,
    output redirect_i,
    output redirect_pc_i,
    input  ifid_valid_o,
    input  ifid_pc_o,
    input  ifid_pc_plus4_o,
    input  ifid_instr_o,
    input  ifid_pred_taken_o,
    input  fetch_count_o
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage of the five-stage pipeline.
// Holds the PC, addresses a combinational-read instruction memory and
// registers the fetched word into IF/ID. Edge priority is
// rst > redirect > stall > normal advance.
// Optional feature macro: IF_STATIC_PREDICT_EN enables static prediction
// (JAL always taken, backward conditional branches taken). Without it the
// next PC is always PC + 4 and the prediction output is tied low.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  instr_fetch_stage_if.master bus
);

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc_q;
  logic        ifid_valid_q;
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_instr_q;
  logic        ifid_pred_q;
  logic [31:0] fetch_count_q;

  logic        pred_taken;
  logic [31:0] next_pc;
  logic [31:0] redirect_target;
  logic        advance;

  // The low two bits of the redirect target are discarded: no compressed ISA.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^bus.redirect_pc_i[1:0];
  assign redirect_target      = {bus.redirect_pc_i[31:2], 2'b00};

  // A real fetch happens only when nothing higher-priority claims the edge.
  assign advance = !bus.redirect_i && !bus.stall_i;

`ifdef IF_STATIC_PREDICT_EN
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [31:0] j_imm;
  logic [31:0] b_imm;
  logic [31:0] pred_offset;

  // Predecode the word on the memory bus into a taken flag and jump offset.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pred_taken  = 1'b0;
    pred_offset = 32'd4;
    j_imm = {{12{bus.imem_rdata_i[31]}}, bus.imem_rdata_i[19:12],
             bus.imem_rdata_i[20], bus.imem_rdata_i[30:21], 1'b0};
    b_imm = {{20{bus.imem_rdata_i[31]}}, bus.imem_rdata_i[7],
             bus.imem_rdata_i[30:25], bus.imem_rdata_i[11:8], 1'b0};
    if (bus.imem_rdata_i[6:0] == OPC_JAL) begin
      pred_taken  = 1'b1;
      pred_offset = j_imm;
    end else if (bus.imem_rdata_i[6:0] == OPC_BRANCH && bus.imem_rdata_i[31]) begin
      pred_taken  = 1'b1;
      pred_offset = b_imm;
    end
  end

  // Sequential or predicted-target next PC, modulo 2^32.
  assign next_pc = pc_q + pred_offset;
`else
  assign pred_taken = 1'b0;
  assign next_pc    = pc_q + 32'd4;
`endif

  // Program counter: reset vector, redirect target, hold, or next fetch address.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      pc_q <= RESET_PC_AL;
    end else if (bus.redirect_i) begin
      pc_q <= redirect_target;
    end else if (!bus.stall_i) begin
      pc_q <= next_pc;
    end
  end

  // IF/ID register: bubble on redirect (pc fields hold), capture on advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'd0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pred_q  <= 1'b0;
    end else if (bus.redirect_i) begin
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pred_q  <= 1'b0;
    end else if (advance) begin
      ifid_valid_q <= 1'b1;
      ifid_pc_q    <= pc_q;
      ifid_instr_q <= bus.imem_rdata_i;
      ifid_pred_q  <= pred_taken;
    end
  end

  // Count of valid instructions loaded into IF/ID; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= 32'd0;
    end else if (advance) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  // The fetch address is the PC register itself: no input-to-address path.
  assign bus.imem_addr_o       = pc_q;
  assign bus.ifid_valid_o      = ifid_valid_q;
  assign bus.ifid_pc_o         = ifid_pc_q;
  assign bus.ifid_pc_plus4_o   = ifid_pc_q + 32'd4;
  assign bus.ifid_instr_o      = ifid_instr_q;
  assign bus.ifid_pred_taken_o = ifid_pred_q;
  assign bus.fetch_count_o     = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed table, hand-written
// prediction sequences, then randomized control traffic against a model.
// Honours IF_STATIC_PREDICT_EN the same way as the design build.
module tb_instr_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_stage_if bus ();

  instr_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction memory: 256 words, aliased on address bits [9:2].
  logic [31:0] mem [0:255];
  assign bus.imem_rdata_i = mem[bus.imem_addr_o[9:2]];

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, clock it, and settle past the edge.
  task automatic apply(input logic r, input logic st, input logic rd, input logic [31:0] rpc);
    rst               = r;
    bus.stall_i       = st;
    bus.redirect_i    = rd;
    bus.redirect_pc_i = rpc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_of(input int i);
    return (32'(i) << 20) | NOP;
  endfunction

  // Static prediction rule: returns {taken, byte offset}.
  function automatic logic [32:0] predict(input logic [31:0] w);
`ifdef IF_STATIC_PREDICT_EN
    int off;
    if (w[6:0] == 7'h6F) begin
      off = int'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      return {1'b1, 32'(off)};
    end
    if (w[6:0] == 7'h63 && w[31]) begin
      off = int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      return {1'b1, 32'(off)};
    end
`endif
    return {1'b0, 32'd4};
  endfunction

  typedef struct {
    logic        r, st, rd;
    logic [31:0] rpc;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs [19];

  // Reference model state
  logic [31:0] m_pc, m_ipc, m_instr, m_cnt;
  logic        m_valid, m_pred;

  task automatic model_step(input logic r, input logic st, input logic rd, input logic [31:0] rpc);
    logic [32:0] p;
    if (r) begin
      m_pc = 32'd0; m_valid = 1'b0; m_ipc = 32'd0; m_instr = NOP; m_pred = 1'b0; m_cnt = 32'd0;
    end else if (rd) begin
      m_pc = rpc & 32'hFFFF_FFFC; m_valid = 1'b0; m_instr = NOP; m_pred = 1'b0;
    end else if (!st) begin
      m_instr = mem[m_pc[9:2]];
      p       = predict(m_instr);
      m_ipc   = m_pc;
      m_valid = 1'b1;
      m_pred  = p[32];
      m_pc    = m_pc + p[31:0];
      m_cnt   = m_cnt + 32'd1;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".addr"},   bus.imem_addr_o, m_pc);
    check({tag, ".valid"},  32'(bus.ifid_valid_o), 32'(m_valid));
    check({tag, ".pc"},     bus.ifid_pc_o, m_ipc);
    check({tag, ".plus4"},  bus.ifid_pc_plus4_o, m_ipc + 32'd4);
    check({tag, ".instr"},  bus.ifid_instr_o, m_instr);
    check({tag, ".pred"},   32'(bus.ifid_pred_taken_o), 32'(m_pred));
    check({tag, ".count"},  bus.fetch_count_o, m_cnt);
  endtask

  logic [31:0] exp_addr;
  logic        exp_pred;

  initial begin
    rst = 1'b1; bus.stall_i = 1'b0; bus.redirect_i = 1'b0; bus.redirect_pc_i = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = word_of(i);

    //            r  st rd rpc            addr           v  pc             instr           cnt
    vecs[0]  = '{1, 0, 0, 32'h0,         32'h0,         0, 32'h0,         NOP,            0};
    vecs[1]  = '{0, 0, 0, 32'h0,         32'h4,         1, 32'h0,         word_of(0),     1};
    vecs[2]  = '{0, 0, 0, 32'h0,         32'h8,         1, 32'h4,         word_of(1),     2};
    vecs[3]  = '{0, 0, 0, 32'h0,         32'hC,         1, 32'h8,         word_of(2),     3};
    vecs[4]  = '{0, 0, 0, 32'h0,         32'h10,        1, 32'hC,         word_of(3),     4};
    vecs[5]  = '{0, 1, 0, 32'h0,         32'h10,        1, 32'hC,         word_of(3),     4};
    vecs[6]  = '{0, 1, 0, 32'h0,         32'h10,        1, 32'hC,         word_of(3),     4};
    vecs[7]  = '{0, 1, 0, 32'h0,         32'h10,        1, 32'hC,         word_of(3),     4};
    vecs[8]  = '{0, 0, 0, 32'h0,         32'h14,        1, 32'h10,        word_of(4),     5};
    vecs[9]  = '{0, 1, 1, 32'h103,       32'h100,       0, 32'h10,        NOP,            5};
    vecs[10] = '{0, 0, 0, 32'h0,         32'h104,       1, 32'h100,       word_of(8'h40), 6};
    vecs[11] = '{0, 0, 1, 32'h200,       32'h200,       0, 32'h100,       NOP,            6};
    vecs[12] = '{0, 0, 1, 32'h300,       32'h300,       0, 32'h100,       NOP,            6};
    vecs[13] = '{0, 0, 0, 32'h0,         32'h304,       1, 32'h300,       word_of(8'hC0), 7};
    vecs[14] = '{1, 0, 1, 32'h400,       32'h0,         0, 32'h0,         NOP,            0};
    vecs[15] = '{0, 0, 0, 32'h0,         32'h4,         1, 32'h0,         word_of(0),     1};
    vecs[16] = '{0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'h0,         NOP,            1};
    vecs[17] = '{0, 0, 0, 32'h0,         32'h0,         1, 32'hFFFF_FFFC, word_of(255),   2};
    vecs[18] = '{1, 1, 0, 32'h0,         32'h0,         0, 32'h0,         NOP,            0};

    for (int i = 0; i < 19; i++) begin
      apply(vecs[i].r, vecs[i].st, vecs[i].rd, vecs[i].rpc);
      check($sformatf("vec%0d.addr", i),  bus.imem_addr_o, vecs[i].e_addr);
      check($sformatf("vec%0d.valid", i), 32'(bus.ifid_valid_o), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d.pc", i),    bus.ifid_pc_o, vecs[i].e_pc);
      check($sformatf("vec%0d.plus4", i), bus.ifid_pc_plus4_o, vecs[i].e_pc + 32'd4);
      check($sformatf("vec%0d.instr", i), bus.ifid_instr_o, vecs[i].e_instr);
      check($sformatf("vec%0d.pred", i),  32'(bus.ifid_pred_taken_o), 32'd0);
      check($sformatf("vec%0d.count", i), bus.fetch_count_o, vecs[i].e_cnt);
    end

    // Prediction corner cases: backward beq, jal +8, forward beq.
    mem[8'h08] = 32'hFE00_0EE3;
    mem[8'h10] = 32'h0080_00EF;
    mem[8'h18] = 32'h0000_0463;
    apply(0, 0, 0, 0);
`ifdef IF_STATIC_PREDICT_EN
    exp_pred = 1'b1;
`else
    exp_pred = 1'b0;
`endif

    apply(0, 0, 1, 32'h20);
    apply(0, 0, 0, 0);
    exp_addr = exp_pred ? 32'h1C : 32'h24;
    check("bwd_beq.addr",  bus.imem_addr_o, exp_addr);
    check("bwd_beq.instr", bus.ifid_instr_o, 32'hFE00_0EE3);
    check("bwd_beq.pred",  32'(bus.ifid_pred_taken_o), 32'(exp_pred));

    apply(0, 0, 1, 32'h40);
    apply(0, 0, 0, 0);
    exp_addr = exp_pred ? 32'h48 : 32'h44;
    check("jal.addr",  bus.imem_addr_o, exp_addr);
    check("jal.pc",    bus.ifid_pc_o, 32'h40);
    check("jal.pred",  32'(bus.ifid_pred_taken_o), 32'(exp_pred));

    apply(0, 0, 1, 32'h60);
    apply(0, 0, 0, 0);
    check("fwd_beq.addr", bus.imem_addr_o, 32'h64);
    check("fwd_beq.pred", 32'(bus.ifid_pred_taken_o), 32'd0);

    // Randomized phase: random program (incl. jumps/branches) and controls.
    for (int i = 0; i < 256; i++) begin
      case ($urandom_range(0, 5))
        0:       mem[i] = ($urandom & 32'hFFFF_FF80) | 32'h6F;
        1:       mem[i] = ($urandom & 32'hFFFF_FF80) | 32'h63;
        2:       mem[i] = ($urandom & 32'hFFFF_FF80) | 32'h67;
        default: mem[i] = $urandom;
      endcase
    end
    apply(1, 0, 0, 0);
    model_step(1, 0, 0, 0);
    check_model("rnd_reset");
    for (int c = 0; c < 3000; c++) begin
      logic r, st, rd;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 63) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      st  = ($urandom_range(0, 4) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 32'h3FF));
      apply(r, st, rd, rpc);
      model_step(r, st, rd, rpc);
      check_model($sformatf("rnd%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Instruction-fetch (IF) stage of the five-stage pipeline core, directly upstream of decode. Holds the program counter, drives the combinational-read instruction memory, and registers the fetched word into the IF/ID pipeline register. Honours stall requests from the hazard unit and redirects from execute. Optionally applies static branch prediction.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset (must be word-aligned)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- imem_addr_o  output  32  fetch address to instruction memory; equals the PC register
- imem_rdata_i  input  32  instruction word at imem_addr_o, same cycle (combinational read)
- stall_i  input  1  hold PC and IF/ID (load-use hazard)
- redirect_i  input  1  execute-stage control-flow correction
- redirect_pc_i  input  32  corrected PC, valid when redirect_i=1
- ifid_valid_o  output  1  IF/ID contents are a real instruction
- ifid_pc_o  output  32  PC of the registered instruction
- ifid_pc_plus4_o  output  32  ifid_pc_o + 4 (mod 2^32)
- ifid_instr_o  output  32  registered instruction word
- ifid_pred_taken_o  output  1  fetch stage predicted this instruction taken
- fetch_count_o  output  32  count of instructions loaded into IF/ID with valid=1

## Operation
- Reset (rst=1 at edge): PC←RESET_PC; ifid_valid_o=0; ifid_instr_o=32'h0000_0013 (NOP); ifid_pc_o=0; ifid_pc_plus4_o=4; ifid_pred_taken_o=0; fetch_count_o=0. Reset overrides all other inputs.
- Priority at each edge: rst > redirect_i > stall_i > normal advance.
- Normal advance: IF/ID←{valid=1, pc=PC, instr=imem_rdata_i, pred}; PC←next_pc; fetch_count_o increments.
- next_pc = pred ? PC + imm : PC + 4. Arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Stall (stall_i=1, redirect_i=0): PC, IF/ID and fetch_count_o hold.
- Redirect (redirect_i=1, regardless of stall_i): PC←{redirect_pc_i[31:2], 2'b00}; IF/ID←bubble (valid=0, instr=NOP, pred=0, pc/pc_plus4 hold); fetch_count_o holds.
- fetch_count_o wraps from 32'hFFFF_FFFF to 0.
- No compressed-instruction support; PC[1:0] is always 00.

## Timing
- imem_addr_o is a direct register output; no combinational path from any input to imem_addr_o.
- Fetch latency: word at PC appears on ifid_instr_o one cycle after PC is presented.
- Redirect asserted in cycle N: imem_addr_o=redirect_pc in cycle N+1; IF/ID shows bubble in N+1; target instruction valid in IF/ID in N+2.
- Stall asserted in cycle N: IF/ID and imem_addr_o identical in N+1 to N; memory is re-read, so imem_rdata_i must be stable for an unchanged address.
- Back-to-back redirects: each takes effect; the last one wins, each producing a bubble.
- Reset mid-stall or mid-redirect: reset values take effect at that edge; fetch resumes at RESET_PC on the first edge after rst deasserts.

## Configuration
- IF_STATIC_PREDICT_EN defined: predecode imem_rdata_i. Opcode 7'b1101111 (JAL): pred=1, imm=J-immediate sign-extended. Opcode 7'b1100011 (branch) with instr[31]=1 (backward): pred=1, imm=B-immediate sign-extended. Forward branches and JALR: pred=0. Execute compares against ifid_pred_taken_o and raises redirect_i on mismatch.
- IF_STATIC_PREDICT_EN undefined: pred=0 always, next_pc=PC+4, ifid_pred_taken_o tied 0, no predecode logic.

## Test plan
- Reset release with RESET_PC=0, memory of NOPs, no stall/redirect -> imem_addr_o 0,4,8,C on successive cycles; ifid_pc_o lags by one cycle; fetch_count_o=4 after 4 advances.
- stall_i=1 for 3 cycles with PC=0x10 -> imem_addr_o stays 0x10, IF/ID holds PC 0x0C, fetch_count_o unchanged; advance resumes with 0x14 next.
- redirect_i=1, redirect_pc_i=0x0000_0103 together with stall_i=1 -> next imem_addr_o=0x100, IF/ID valid=0/instr=0x13; next cycle IF/ID pc=0x100 valid=1.
- PC=0xFFFF_FFFC, normal advance -> imem_addr_o wraps to 0x0, ifid_pc_plus4_o=0x0.
- With IF_STATIC_PREDICT_EN: at PC=0x20 fetch 0xFE000EE3 (beq x0,x0,-4) -> next imem_addr_o=0x1C, ifid_pred_taken_o=1; fetch 0x008000EF (jal x1,+8) at 0x40 -> next 0x48; forward beq -> PC+4, pred=0. Without macro: all three -> PC+4, pred=0.
- rst=1 asserted during redirect -> PC=RESET_PC, IF/ID=reset values, fetch_count_o=0.
